spi_reg_write_ctrl: RTL

//  Sequences the byte stream from spi_slave into register-file writes.

---
 rtl/spi_reg_write_ctrl.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/spi_reg_write_ctrl.sv
// Purpose : turns SPI frames {cmd=1,addr[6:0]}, data... into register-file writes via a write FIFO.
// Latency : push on the edge ending rx_valid, head visible next cycle; status pulses one cycle after msg_end.
// Backpressure: reg_wr_ready low holds the FIFO head; a push into a full FIFO is dropped and flagged as overflow.
// Optional checksum build: define SPI_REG_WRITE_CTRL_CHECKSUM_EN (last byte is an XOR checksum, writes are all-or-nothing).
module spi_reg_write_ctrl #(
  parameter int ADDR_W     = 7,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_msg_start,
  input  logic              i_msg_end,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  input  logic              i_rx_corrupt,
  output logic              o_reg_wr_valid,
  input  logic              i_reg_wr_ready,
  output logic [ADDR_W-1:0] o_reg_wr_addr,
  output logic [7:0]        o_reg_wr_data,
  output logic              o_frame_ok,
  output logic              o_frame_err,
  output logic [3:0]        o_err_flags,
  output logic [7:0]        o_err_count
);

  localparam int IDX_W = $clog2(FIFO_DEPTH);
  localparam int PTR_W = IDX_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_DISCARD} state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_ovf, r_bad, r_any;
  logic [PTR_W-1:0]  r_rd_ptr, r_wr_ptr;
  logic [ADDR_W-1:0] r_mem_addr [FIFO_DEPTH];
  logic [7:0]        r_mem_data [FIFO_DEPTH];
  logic              r_frame_ok, r_frame_err;
  logic [3:0]        r_err_flags;
  logic [7:0]        r_err_count;

  logic              w_byte, w_push_req, w_bad_now, w_abort, w_close;
  logic              w_full, w_push, w_pop, w_ovf, w_bad, w_any, w_cs_fail;
  logic              w_report, w_frame_fail, w_ok, w_err;
  logic [3:0]        w_frame_flags, w_flags_out;
  logic [PTR_W-1:0]  w_commit;

`ifdef SPI_REG_WRITE_CTRL_CHECKSUM_EN
  logic [7:0]        r_xor, w_xor;
  logic [PTR_W-1:0]  r_commit_ptr, w_wr_nxt;
  assign w_xor     = r_xor ^ (w_byte ? i_rx_data : 8'h00);
  assign w_cs_fail = (w_xor != 8'h00);
  assign w_commit  = r_commit_ptr;
  assign w_wr_nxt  = r_wr_ptr + (w_push ? PTR_W'(1) : PTR_W'(0));
`else
  assign w_cs_fail = 1'b0;
  assign w_commit  = r_wr_ptr;
`endif

  // FSM next state and per-cycle frame events; msg_start has priority over bytes and msg_end
  always_comb begin
    w_state_nxt = r_state;
    w_byte      = 1'b0;
    w_push_req  = 1'b0;
    w_bad_now   = 1'b0;
    w_abort     = 1'b0;
    w_close     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_msg_start) w_state_nxt = S_CMD;
      end
      S_CMD: begin
        if (i_msg_start) begin
          w_abort     = 1'b1;
          w_state_nxt = S_CMD;
        end else begin
          if (i_rx_valid) begin
            w_byte = 1'b1;
            if (i_rx_data[7]) begin
              w_state_nxt = S_DATA;
            end else begin
              w_bad_now   = 1'b1;
              w_state_nxt = S_DISCARD;
            end
          end
          if (i_msg_end) begin
            w_close     = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (i_msg_start) begin
          w_abort     = 1'b1;
          w_state_nxt = S_CMD;
        end else begin
          if (i_rx_valid) begin
            w_byte     = 1'b1;
            w_push_req = 1'b1;
          end
          if (i_msg_end) begin
            w_close     = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        if (i_msg_start) begin
          w_abort     = 1'b1;
          w_state_nxt = S_CMD;
        end else if (i_msg_end) begin
          w_close     = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
    endcase
  end

  // Full is judged on registered pointers, i.e. before any same-cycle pop
  assign w_full         = ((r_wr_ptr - r_rd_ptr) == PTR_W'(FIFO_DEPTH));
  assign w_push         = w_push_req && !w_full;
  assign w_ovf          = r_ovf | (w_push_req & w_full);
  assign w_bad          = r_bad | w_bad_now;
  assign w_any          = r_any | w_byte;
  assign w_frame_flags  = {w_ovf, w_cs_fail, w_bad, i_rx_corrupt};
  // An empty frame (no bytes, no partial byte) closes silently
  assign w_report       = w_close && (w_any || i_rx_corrupt);
  assign w_frame_fail   = w_report && (w_frame_flags != 4'b0000);
  assign w_ok           = w_report && !w_frame_fail;
  assign w_err          = w_frame_fail || w_abort;
  assign w_flags_out    = w_abort ? {r_ovf, 1'b0, r_bad, 1'b1} : w_frame_flags;

  assign o_reg_wr_valid = (w_commit != r_rd_ptr);
  assign w_pop          = o_reg_wr_valid && i_reg_wr_ready;
  assign o_reg_wr_addr  = o_reg_wr_valid ? r_mem_addr[r_rd_ptr[IDX_W-1:0]] : '0;
  assign o_reg_wr_data  = o_reg_wr_valid ? r_mem_data[r_rd_ptr[IDX_W-1:0]] : 8'h00;
  assign o_frame_ok     = r_frame_ok;
  assign o_frame_err    = r_frame_err;
  assign o_err_flags    = r_err_flags;
  assign o_err_count    = r_err_count;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Per-frame accumulators, cleared whenever a new frame starts
  always_ff @(posedge clk) begin
    if (rst || i_msg_start) begin
      r_ovf <= 1'b0;
      r_bad <= 1'b0;
      r_any <= 1'b0;
`ifdef SPI_REG_WRITE_CTRL_CHECKSUM_EN
      r_xor <= 8'h00;
`endif
    end else begin
      r_ovf <= w_ovf;
      r_bad <= w_bad;
      r_any <= w_any;
`ifdef SPI_REG_WRITE_CTRL_CHECKSUM_EN
      r_xor <= w_xor;
`endif
    end
  end

  // Write address: loaded from the command byte, advanced (mod 2^ADDR_W) per data byte
  always_ff @(posedge clk) begin
    if (rst)                          r_addr <= '0;
    else if (r_state == S_CMD && w_byte) r_addr <= i_rx_data[ADDR_W-1:0];
    else if (w_push_req)              r_addr <= r_addr + ADDR_W'(1);
  end

  // FIFO pointers; in the checksum build writes stay speculative until a clean msg_end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
`ifdef SPI_REG_WRITE_CTRL_CHECKSUM_EN
      r_commit_ptr <= '0;
`endif
    end else begin
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
`ifdef SPI_REG_WRITE_CTRL_CHECKSUM_EN
      if (w_abort || w_frame_fail) r_wr_ptr <= r_commit_ptr;
      else                         r_wr_ptr <= w_wr_nxt;
      // the final pushed byte is the checksum itself and is never committed
      if (w_ok) r_commit_ptr <= w_wr_nxt - PTR_W'(1);
`else
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
`endif
    end
  end

  // FIFO storage; contents are don't-care until committed
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_addr[r_wr_ptr[IDX_W-1:0]] <= r_addr;
      r_mem_data[r_wr_ptr[IDX_W-1:0]] <= i_rx_data;
    end
  end

  // Frame status pulses, held flags and saturating error count
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_ok  <= 1'b0;
      r_frame_err <= 1'b0;
      r_err_flags <= 4'b0000;
      r_err_count <= 8'h00;
    end else begin
      r_frame_ok  <= w_ok;
      r_frame_err <= w_err;
      if (w_ok || w_err) r_err_flags <= w_flags_out;
      if (w_err && r_err_count != 8'hFF) r_err_count <= r_err_count + 8'h01;
    end
  end

endmodule
